// File: rtl/bnor_bist_ctrl.sv
// Self-test sequencer for a single 2-input NOR cell: walks the four input
// vectors, waits a settle time per vector, samples y and tallies mismatches.
module bnor_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             nor_a,
  output logic             nor_b,
  input  logic             nor_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0]       RELOAD  = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       ff_q, ff_d;
  logic             mism;
  logic [1:0]       vec_nx;

  assign mism   = (nor_y != ~(a_q | b_q));
  assign vec_nx = vec_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE, SAMPLE: begin
        // abort wins over any sample bookkeeping in the same cycle
        if (abort) begin
          state_d = IDLE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (state_q == SETTLE) begin
          if (cnt_q == 4'd0) state_d = SAMPLE;
          else               cnt_d   = cnt_q - 4'd1;
        end else begin
          if (mism) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            // err_cnt never returns to zero mid-run, so zero marks "no mismatch yet"
            if (err_q == '0) ff_d = {a_q, b_q};
          end
          if (vec_q == 2'd3) begin
            state_d = DONE;
            busy_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (err_d == '0);
          end else begin
            vec_d      = vec_nx;
            {a_d, b_d} = vec_nx;
            cnt_d      = RELOAD;
            state_d    = SETTLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign nor_a      = a_q;
  assign nor_b      = b_q;
  assign busy       = busy_q;
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_bnor_bist_ctrl.sv
// Bench for bnor_bist_ctrl: a truth-table cell model drives y; a table of
// known cells, hand sequences (re-pulse, abort, reset) and random cells.
module tb_bnor_bist_ctrl;
  localparam int S   = 2;
  localparam int LAT = 4 * (S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] lut;
  logic       nor_a, nor_b, nor_y, busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] first_fail;
  logic       nor_a1, nor_b1, nor_y1, busy1, done1, pass1;
  logic [0:0] err_cnt1;
  logic [1:0] first_fail1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // cell under test: y = lut[{a,b}]
  assign nor_y  = lut[{nor_a, nor_b}];
  assign nor_y1 = lut[{nor_a1, nor_b1}];

  bnor_bist_ctrl #(.SETTLE_CYCLES(S), .ERR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .nor_a(nor_a), .nor_b(nor_b), .nor_y(nor_y),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail));

  bnor_bist_ctrl #(.SETTLE_CYCLES(S), .ERR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .nor_a(nor_a1), .nor_b(nor_b1), .nor_y(nor_y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .first_fail(first_fail1));

  typedef struct {
    logic [3:0] lut;
    int         err;
    int         err1;
    int         ff;
    bit         pass;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // reference: compare the cell's truth table against NOR vector by vector
  function automatic void model(input logic [3:0] l, output int err, output int err1,
                                output int ff, output bit p);
    int n = 0;
    ff = 0;
    for (int i = 0; i < 4; i++) begin
      bit expy = (i == 0);
      if (l[i] != expy) begin
        if (n == 0) ff = i;
        n++;
      end
    end
    err  = (n > 7) ? 7 : n;
    err1 = (n > 1) ? 1 : n;
    p    = (n == 0);
  endfunction

  task automatic run(input logic [3:0] l, input bit repulse, input string tag);
    int e, e1, ff;
    bit p;
    model(l, e, e1, ff, p);
    lut = l;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      start = repulse && (c == 3 || c == LAT);
      if (c < LAT) begin
        chk($sformatf("%s busy c%0d", tag, c), busy, 1);
        chk($sformatf("%s done c%0d", tag, c), done, 0);
        chk($sformatf("%s vec c%0d", tag, c), {nor_a, nor_b}, (c - 1) / (S + 1));
      end else if (c == LAT) begin
        chk($sformatf("%s done", tag), done, 1);
        chk($sformatf("%s busy@done", tag), busy, 0);
        chk($sformatf("%s ab@done", tag), {nor_a, nor_b}, 0);
        chk($sformatf("%s pass", tag), pass, p);
        chk($sformatf("%s err", tag), err_cnt, e);
        chk($sformatf("%s err1", tag), err_cnt1, e1);
        chk($sformatf("%s pass1", tag), pass1, p);
        if (!p) chk($sformatf("%s ff", tag), first_fail, ff);
      end else begin
        chk($sformatf("%s done after", tag), done, 0);
        chk($sformatf("%s busy after", tag), busy, 0);
        chk($sformatf("%s pass hold", tag), pass, p);
        chk($sformatf("%s err hold", tag), err_cnt, e);
      end
    end
    if (repulse) begin
      repeat (4) begin
        @(negedge clk);
        chk($sformatf("%s no rerun done", tag), done, 0);
        chk($sformatf("%s no rerun busy", tag), busy, 0);
      end
    end
  endtask

  initial begin
    tbl[0] = '{4'b0001, 0, 0, 0, 1'b1};  // good NOR
    tbl[1] = '{4'b0000, 1, 1, 0, 1'b0};  // stuck-at-0
    tbl[2] = '{4'b1111, 3, 1, 1, 1'b0};  // stuck-at-1
    tbl[3] = '{4'b1110, 4, 1, 0, 1'b0};  // wired as OR

    rst = 1'b1; start = 1'b0; abort = 1'b0; lut = 4'b0001;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst err", err_cnt, 0);
    chk("rst ff", first_fail, 0);
    chk("rst ab", {nor_a, nor_b}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table: hand-derived expectations, applied in order
    for (int i = 0; i < 4; i++) begin
      int e, e1, ff;
      bit p;
      model(tbl[i].lut, e, e1, ff, p);
      chk($sformatf("tbl%0d model err", i), e, tbl[i].err);
      chk($sformatf("tbl%0d model err1", i), e1, tbl[i].err1);
      chk($sformatf("tbl%0d model ff", i), ff, tbl[i].ff);
      run(tbl[i].lut, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d err direct", i), err_cnt, tbl[i].err);
      chk($sformatf("tbl%0d ff direct", i), first_fail, tbl[i].ff);
      chk($sformatf("tbl%0d pass direct", i), pass, tbl[i].pass);
    end

    // start re-pulsed mid-run and during DONE is ignored
    run(4'b0001, 1'b1, "repulse");

    // abort in IDLE does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort busy", busy, 0);
    chk("idle abort pass", pass, 1);

    // abort during SAMPLE of vector 01 on an OR cell: only the 00 miss counts
    lut = 4'b1110;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort busy c6", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy c7", busy, 0);
    chk("abort done c7", done, 0);
    chk("abort pass", pass, 0);
    chk("abort ab", {nor_a, nor_b}, 0);
    chk("abort err partial", err_cnt, 1);
    chk("abort ff partial", first_fail, 0);
    repeat (12) begin
      @(negedge clk);
      chk("abort no done", done, 0);
      chk("abort stays idle", busy, 0);
    end

    // async reset while vector 10 is settling
    lut = 4'b1110;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-rst vec", {nor_a, nor_b}, 2);
    chk("pre-rst err", err_cnt, 2);
    rst = 1'b1;
    #1;
    chk("async rst ab", {nor_a, nor_b}, 0);
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst err", err_cnt, 0);
    chk("async rst ff", first_fail, 0);
    chk("async rst pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(4'b0001, 1'b0, "post-rst");

    // random cells, random gaps, random re-pulses
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
